// File: rtl/usrt_apb_master_pkg.sv
// rtl/usrt_apb_master_pkg.sv - shared state encoding, widths and address map for the USRT APB initiator
package usrt_apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned USRT_ADDR_WIDTH     = 1;
  localparam int unsigned USRT_DATA_WIDTH     = 8;
  localparam int unsigned USRT_TIMEOUT_CYCLES = 65535;

  // USRT register map: address 1 is the UART data register
  localparam logic [USRT_ADDR_WIDTH-1:0] USRT_ADDR_DATA = 1'b1;

endpackage

// File: rtl/usrt_apb_master_if.sv
// rtl/usrt_apb_master_if.sv - command/response handshake plus APB bus seen by the USRT APB initiator
interface usrt_apb_master_if
  import usrt_apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = USRT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = USRT_DATA_WIDTH
) ();

  logic                  i_Cmd_Valid;
  logic                  o_Cmd_Ready;
  logic                  i_Cmd_Write;
  logic [ADDR_WIDTH-1:0] i_Cmd_Addr;
  logic [DATA_WIDTH-1:0] i_Cmd_Wdata;
  logic                  o_Rsp_Valid;
  logic                  i_Rsp_Ready;
  logic [DATA_WIDTH-1:0] o_Rsp_Rdata;
  logic                  o_Rsp_Error;
  logic [ADDR_WIDTH-1:0] o_Paddr;
  logic                  o_Psel;
  logic                  o_Penable;
  logic                  o_Pwrite;
  logic [DATA_WIDTH-1:0] o_Pwdata;
  logic                  i_Pready;
  logic [DATA_WIDTH-1:0] i_Prdata;

  modport master (
    input  i_Cmd_Valid, i_Cmd_Write, i_Cmd_Addr, i_Cmd_Wdata, i_Rsp_Ready, i_Pready, i_Prdata,
    output o_Cmd_Ready, o_Rsp_Valid, o_Rsp_Rdata, o_Rsp_Error,
           o_Paddr, o_Psel, o_Penable, o_Pwrite, o_Pwdata
  );

  modport slave (
    output i_Cmd_Valid, i_Cmd_Write, i_Cmd_Addr, i_Cmd_Wdata, i_Rsp_Ready, i_Pready, i_Prdata,
    input  o_Cmd_Ready, o_Rsp_Valid, o_Rsp_Rdata, o_Rsp_Error,
           o_Paddr, o_Psel, o_Penable, o_Pwrite, o_Pwdata
  );

endinterface

// File: rtl/usrt_wait_timer.sv
// rtl/usrt_wait_timer.sv - 16-bit ACCESS wait counter flagging when LIMIT stalled cycles have elapsed
module usrt_wait_timer #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Expired during the last permitted stalled cycle, so the abort lands on the following edge
  assign expired_o = (count_q == 16'(LIMIT - 1));

endmodule

// File: rtl/usrt_apb_master.sv
// rtl/usrt_apb_master.sv - APB initiator for the USRT slave; optional ACCESS timeout via USRT_APB_TIMEOUT_EN
module usrt_apb_master
  import usrt_apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = USRT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = USRT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = USRT_TIMEOUT_CYCLES
) (
  input  logic              i_Pclk,
  input  logic              i_Preset_n,
  usrt_apb_master_if.master bus
);

  apb_state_e            state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

`ifdef USRT_APB_TIMEOUT_EN
  logic rsp_error_q;
  logic expired;

  usrt_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (i_Pclk),
    .rst_n     (i_Preset_n),
    .clear_i   (state_q == ST_SETUP),
    .enable_i  ((state_q == ST_ACCESS) && !bus.i_Pready),
    .expired_o (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge i_Pclk or negedge i_Preset_n) begin
    if (!i_Preset_n) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef USRT_APB_TIMEOUT_EN
      rsp_error_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_Cmd_Valid) begin
            paddr_q  <= bus.i_Cmd_Addr;
            pwrite_q <= bus.i_Cmd_Write;
            pwdata_q <= bus.i_Cmd_Wdata;
            psel_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // The USRT slave stretches PREADY until the UART byte has shifted
          if (bus.i_Pready) begin
            rsp_rdata_q <= pwrite_q ? '0 : bus.i_Prdata;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
`ifdef USRT_APB_TIMEOUT_EN
          else if (expired) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          if (bus.i_Rsp_Ready) begin
            rsp_valid_q <= 1'b0;
`ifdef USRT_APB_TIMEOUT_EN
            rsp_error_q <= 1'b0;
`endif
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_Cmd_Ready = (state_q == ST_IDLE);
  assign bus.o_Psel      = psel_q;
  assign bus.o_Penable   = penable_q;
  assign bus.o_Pwrite    = pwrite_q;
  assign bus.o_Paddr     = paddr_q;
  assign bus.o_Pwdata    = pwdata_q;
  assign bus.o_Rsp_Valid = rsp_valid_q;
  assign bus.o_Rsp_Rdata = rsp_rdata_q;
`ifdef USRT_APB_TIMEOUT_EN
  assign bus.o_Rsp_Error = rsp_error_q;
`else
  assign bus.o_Rsp_Error = 1'b0;
`endif

endmodule

// File: tb/tb_usrt_apb_master.sv
// tb/tb_usrt_apb_master.sv - randomized self-checking bench for usrt_apb_master (USRT_APB_TIMEOUT_EN aware)
module tb_usrt_apb_master;
  import usrt_apb_master_pkg::*;

  localparam int unsigned AW = 1;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  usrt_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  usrt_apb_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_Pclk     (clk),
    .i_Preset_n (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer: the expected response comes only from the command and the slave's answer
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int waits, input logic [DW-1:0] rd, input int hold, input logic b2b);
    logic [DW-1:0] exp_rd;
    logic          stable;
    int            acc;
    exp_rd = wr ? '0 : rd;
    bus.i_Cmd_Write = wr;
    bus.i_Cmd_Addr  = addr;
    bus.i_Cmd_Wdata = wd;
    bus.i_Cmd_Valid = 1'b1;
    chk("cmd_ready_idle", 32'(bus.o_Cmd_Ready), 32'd1);
    tick();
    bus.i_Cmd_Valid = 1'b0;
    bus.i_Pready    = 1'b1;
    bus.i_Prdata    = ~rd;
    chk("setup_psel", 32'(bus.o_Psel), 32'd1);
    chk("setup_penable", 32'(bus.o_Penable), 32'd0);
    chk("setup_paddr", 32'(bus.o_Paddr), 32'(addr));
    chk("setup_pwrite", 32'(bus.o_Pwrite), 32'(wr));
    chk("setup_pwdata", 32'(bus.o_Pwdata), 32'(wd));
    chk("setup_cmd_ready", 32'(bus.o_Cmd_Ready), 32'd0);
    tick();
    acc    = 0;
    stable = 1'b1;
    repeat (waits + 1) begin
      if (!(bus.o_Psel && bus.o_Penable && bus.o_Paddr == addr && bus.o_Pwrite == wr &&
            bus.o_Pwdata == wd && !bus.o_Rsp_Valid)) stable = 1'b0;
      bus.i_Pready = (acc == waits);
      bus.i_Prdata = (acc == waits) ? rd : ~rd;
      acc++;
      tick();
    end
    bus.i_Pready = 1'(($urandom));
    bus.i_Prdata = 8'($urandom);
    chk("access_stable", 32'(stable), 32'd1);
    chk("rsp_valid", 32'(bus.o_Rsp_Valid), 32'd1);
    chk("rsp_rdata", 32'(bus.o_Rsp_Rdata), 32'(exp_rd));
    chk("rsp_error", 32'(bus.o_Rsp_Error), 32'd0);
    chk("rsp_psel_low", 32'({bus.o_Psel, bus.o_Penable}), 32'd0);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.i_Rsp_Ready = 1'b0;
      tick();
      if (!(bus.o_Rsp_Valid && bus.o_Rsp_Rdata == exp_rd && !bus.o_Cmd_Ready && !bus.o_Psel))
        stable = 1'b0;
    end
    chk("rsp_hold_stable", 32'(stable), 32'd1);
    bus.i_Rsp_Ready = 1'b1;
    bus.i_Cmd_Valid = b2b;
    tick();
    bus.i_Rsp_Ready = 1'b0;
    chk("rsp_done_valid", 32'(bus.o_Rsp_Valid), 32'd0);
    chk("rsp_done_cmd_ready", 32'(bus.o_Cmd_Ready), 32'd1);
    chk("no_accept_on_resp_edge", 32'(bus.o_Psel), 32'd0);
    chk("rdata_holds", 32'(bus.o_Rsp_Rdata), 32'(exp_rd));
    chk("paddr_holds", 32'(bus.o_Paddr), 32'(addr));
    chk("pwdata_holds", 32'(bus.o_Pwdata), 32'(wd));
    bus.i_Cmd_Valid = 1'b0;
  endtask

  initial begin
    int acc;
    errors = 0;
    checks = 0;
    bus.i_Cmd_Valid = 1'b0;
    bus.i_Cmd_Write = 1'b0;
    bus.i_Cmd_Addr  = '0;
    bus.i_Cmd_Wdata = '0;
    bus.i_Rsp_Ready = 1'b0;
    bus.i_Pready    = 1'b0;
    bus.i_Prdata    = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_psel", 32'(bus.o_Psel), 32'd0);
    chk("rst_bus", 32'({bus.o_Penable, bus.o_Pwrite, bus.o_Paddr, bus.o_Pwdata}), 32'd0);
    chk("rst_rsp", 32'({bus.o_Rsp_Valid, bus.o_Rsp_Error, bus.o_Rsp_Rdata}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(bus.o_Cmd_Ready), 32'd1);

    // Idle with no command: nothing moves even with PREADY high
    bus.i_Pready = 1'b1;
    repeat (3) tick();
    chk("idle_no_psel", 32'(bus.o_Psel), 32'd0);
    chk("idle_no_rsp", 32'(bus.o_Rsp_Valid), 32'd0);

`ifndef USRT_APB_TIMEOUT_EN
    do_xfer(1'b0, USRT_ADDR_DATA, 8'h00, 900, 8'h53, 0, 1'b0);
`else
    do_xfer(1'b0, USRT_ADDR_DATA, 8'h00, int'(TO) - 1, 8'h53, 0, 1'b0);
`endif
    do_xfer(1'b1, USRT_ADDR_DATA, 8'h53, 0, 8'hC4, 0, 1'b0);
    do_xfer(1'b0, USRT_ADDR_DATA, 8'h11, 2, 8'h9E, 10, 1'b0);
    for (int n = 0; n < 24; n++) begin
      do_xfer(1'($urandom), AW'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
              8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset pulse in the middle of ACCESS
    bus.i_Cmd_Write = 1'b1;
    bus.i_Cmd_Addr  = 1'b1;
    bus.i_Cmd_Wdata = 8'h7F;
    bus.i_Cmd_Valid = 1'b1;
    tick();
    bus.i_Cmd_Valid = 1'b0;
    bus.i_Pready    = 1'b0;
    tick();
    tick();
    chk("pre_rst_access", 32'({bus.o_Psel, bus.o_Penable}), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 32'({bus.o_Psel, bus.o_Penable}), 32'd0);
    chk("mid_rst_rsp", 32'(bus.o_Rsp_Valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_Pready = 1'b1;
    tick();
    chk("post_rst_cmd_ready", 32'(bus.o_Cmd_Ready), 32'd1);
    repeat (3) tick();
    chk("post_rst_no_rsp", 32'({bus.o_Rsp_Valid, bus.o_Psel}), 32'd0);

`ifdef USRT_APB_TIMEOUT_EN
    bus.i_Cmd_Write = 1'b0;
    bus.i_Cmd_Addr  = 1'b1;
    bus.i_Cmd_Valid = 1'b1;
    tick();
    bus.i_Cmd_Valid = 1'b0;
    bus.i_Pready    = 1'b0;
    bus.i_Prdata    = 8'hA5;
    tick();
    acc = 0;
    while (!bus.o_Rsp_Valid && acc < 100) begin
      acc++;
      tick();
    end
    chk("timeout_access_cycles", 32'(acc), 32'(TO));
    chk("timeout_error", 32'(bus.o_Rsp_Error), 32'd1);
    chk("timeout_rdata", 32'(bus.o_Rsp_Rdata), 32'd0);
    chk("timeout_psel", 32'({bus.o_Psel, bus.o_Penable}), 32'd0);
    bus.i_Rsp_Ready = 1'b1;
    tick();
    bus.i_Rsp_Ready = 1'b0;
    chk("timeout_error_clear", 32'({bus.o_Rsp_Valid, bus.o_Rsp_Error}), 32'd0);
`else
    acc = 0;
    chk("no_timeout_counter", 32'(acc), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Protocol watch: PENABLE may only rise in the cycle after a SETUP cycle
  logic prev_setup;
  always @(negedge clk) begin
    if (rst_n && bus.o_Penable && !bus.o_Psel) begin
      chk("penable_without_psel", 32'd1, 32'd0);
    end
    if (rst_n && bus.o_Psel && !bus.o_Penable && prev_setup) begin
      chk("setup_longer_than_one", 32'd1, 32'd0);
    end
    prev_setup = rst_n && bus.o_Psel && !bus.o_Penable;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
